// File: rtl/hdu_pkg.sv
// rtl/hdu_pkg.sv - shared types and constants for the hazard detection unit
package hdu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_USE = 2'd1,
        MEM_WAIT = 2'd2
    } hdu_state_e;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         WAIT_W_DEF = 4;
    localparam int         CNT_W_DEF  = 16;

    function automatic logic src_match(input logic use_rs, input logic [4:0] rs, input logic [4:0] rd);
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// rtl/hazard_detection_unit_if.sv - pipeline-side hazard inputs and stall/flush controls
interface hazard_detection_unit_if #(
    parameter int CNT_W = hdu_pkg::CNT_W_DEF
);
    logic [4:0]       register_addr1_ID;
    logic [4:0]       register_addr2_ID;
    logic             use_rs1_ID;
    logic             use_rs2_ID;
    logic [4:0]       register_rd_IDEX;
    logic             mem_read_IDEX;
    logic             branch_taken_EX;
    logic             mem_req_EXMEM;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_err;

    // Pipeline side: supplies hazard sources, consumes enables.
    modport master (
        output register_addr1_ID, register_addr2_ID, use_rs1_ID, use_rs2_ID,
               register_rd_IDEX, mem_read_IDEX, branch_taken_EX, mem_req_EXMEM, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               stall_count, timeout_err
    );

    modport slave (
        input  register_addr1_ID, register_addr2_ID, use_rs1_ID, use_rs2_ID,
               register_rd_IDEX, mem_read_IDEX, branch_taken_EX, mem_req_EXMEM, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               stall_count, timeout_err
    );

endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use RAW comparator
module load_use_detect
    import hdu_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rd,
    input  logic       mem_read,
    output logic       lu
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu = mem_read && (rd != REG_ZERO) &&
                (src_match(use_rs1, rs1, rd) || src_match(use_rs2, rs2, rd));

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - stall/flush controller for load-use, memory wait and taken branches
module hazard_detection_unit
    import hdu_pkg::*;
#(
    parameter int WAIT_W = WAIT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    arst_n,
    hazard_detection_unit_if.slave  hz
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    hdu_state_e        state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt;
    logic              timeout_q;

    logic lu, ms;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
    logic wait_inc, wait_clr;

    load_use_detect u_lud (
        .rs1      (hz.register_addr1_ID),
        .rs2      (hz.register_addr2_ID),
        .use_rs1  (hz.use_rs1_ID),
        .use_rs2  (hz.use_rs2_ID),
        .rd       (hz.register_rd_IDEX),
        .mem_read (hz.mem_read_IDEX),
        .lu       (lu)
    );

    assign ms = hz.mem_req_EXMEM && !hz.mem_ready;

    always_comb begin
        state_next  = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        wait_inc    = 1'b0;
        wait_clr    = 1'b0;
        case (state)
            RUN, LOAD_USE: begin
                if (ms) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                    state_next  = MEM_WAIT;
                end else if (hz.branch_taken_EX) begin
                    // ID holds a wrong-path instruction, so any load-use on it is moot.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_next  = RUN;
                end else if (lu && (state == RUN)) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_next  = LOAD_USE;
                end else begin
                    state_next  = RUN;
                end
            end
            MEM_WAIT: begin
                // EX is frozen here; a taken branch is picked up again once back in RUN.
                if (!hz.mem_ready) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                    wait_inc    = 1'b1;
                end else begin
                    wait_clr    = 1'b1;
                    state_next  = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (wait_clr) begin
            wait_cnt_next = '0;
        end else if (wait_inc && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (!pc_write && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            // Sticky: the FSM keeps waiting, software sees the error until reset.
            if (wait_cnt_next == WAIT_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.pipe_freeze = pipe_freeze;
    assign hz.stall_count = stall_cnt;
    assign hz.timeout_err = timeout_q;

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline stall/flush controller: the control-side counterpart of the operand forwarding logic. Where forwarding resolves RAW hazards by steering values, this block resolves the hazards forwarding cannot cover:
- load-use, by inserting one bubble;
- variable-latency data memory, by freezing the pipeline;
- taken branches, by flushing wrong-path instructions.

It sits beside the ID stage and drives the PC and pipeline-register enables and flush controls.

## Interface
Parameters:
- WAIT_W, 4: width of memory-wait counter; timeout when count reaches 2^WAIT_W-1
- CNT_W, 16: width of stall performance counter

Ports:
- clk  in  1  core clock, rising edge
- arst_n  in  1  asynchronous, active-low reset
- register_addr1_ID  in  5  rs1 of instruction in ID
- register_addr2_ID  in  5  rs2 of instruction in ID
- use_rs1_ID  in  1  ID instruction reads rs1
- use_rs2_ID  in  1  ID instruction reads rs2
- register_rd_IDEX  in  5  rd of instruction in EX
- mem_read_IDEX  in  1  instruction in EX is a load
- branch_taken_EX  in  1  branch/jump in EX resolved taken
- mem_req_EXMEM  in  1  load/store in MEM stage this cycle
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_count  out  CNT_W  cycles with pc_write=0, saturating
- timeout_err  out  1  sticky: memory wait hit timeout

## Operation
- State machine, states RUN, LOAD_USE, MEM_WAIT; reset state RUN.
- Outputs are combinational from state and inputs. stall_count, timeout_err and the wait counter are registered.
- Load-use hazard (lu) is true when all hold:
  - mem_read_IDEX = 1 and register_rd_IDEX != 0
  - and (use_rs1_ID and rd == rs1) or (use_rs2_ID and rd == rs2)
- Memory stall (ms) = mem_req_EXMEM and !mem_ready.
- RUN, by priority:
  1. ms: pc_write=0, ifid_write=0, pipe_freeze=1; next MEM_WAIT.
  2. branch_taken_EX: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; next RUN. A branch overrides lu, because the ID instruction is wrong-path.
  3. lu: pc_write=0, ifid_write=0, idex_bubble=1; next LOAD_USE.
  4. Otherwise: pc_write=1, ifid_write=1, all others 0.
- LOAD_USE lasts one cycle; lu detection is suppressed. ms and branch are handled as in RUN. Next state is MEM_WAIT on ms, else RUN.
- MEM_WAIT:
  - While !mem_ready: pc_write=0, ifid_write=0, pipe_freeze=1, flush/bubble=0; the wait counter increments, saturating.
  - On mem_ready=1: all enables released that cycle, next RUN, wait counter cleared.
  - branch_taken_EX is ignored (EX is frozen) and is re-evaluated in RUN.
- Timeout: when the wait counter reaches 2^WAIT_W-1, timeout_err sets and holds until reset. The FSM keeps waiting.
- stall_count increments every cycle in which pc_write=0 and saturates at all-ones.

## Timing
- Reset (arst_n=0, asynchronous): state=RUN, wait counter=0, stall_count=0, timeout_err=0.
- With all inputs at 0 after reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
- Output latency: 0 cycles from inputs. The effect lands on the next rising edge of clk.
- Load-use costs exactly 1 stall cycle. A memory wait costs N cycles, where N is the number of cycles with mem_ready=0.
- mem_ready=1 in the first cycle of mem_req_EXMEM gives no stall.
- rd=x0 never stalls.
- Reset asserted mid-stall returns to RUN immediately; a pending stall is dropped.

## Structure
- Package hdu_pkg holds:
  - state enum (RUN, LOAD_USE, MEM_WAIT)
  - REG_ZERO = 5'd0
  - default WAIT_W/CNT_W constants
- One sub-module, load_use_detect: purely combinational lu comparator. FSM, counters and output decode stay in the top.

## Test plan
- rd_IDEX=5, mem_read=1, rs1=5, use_rs1=1 -> one cycle: pc_write=0, idex_bubble=1. Next cycle all enables 1. stall_count=1.
- Same, but rd=0, or use_rs1=0 with rs2 not matching -> no stall.
- lu and branch_taken_EX same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, state stays RUN.
- mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_freeze=1 for 3 cycles, released in the ready cycle, stall_count=3.
- WAIT_W=4, mem_ready held 0 for 20 cycles -> timeout_err rises when the counter reaches 15 and stays 1 after ready. arst_n pulse clears it.
- arst_n low during MEM_WAIT -> state RUN, outputs at reset values, stall_count=0.
